// File: rtl/display_pkg.sv
// Shared constants and the clamp helper for the display source sampler.
package display_pkg;

  localparam logic [1:0] SRC_MMIO   = 2'd0;
  localparam logic [1:0] SRC_PC     = 2'd1;
  localparam logic [1:0] SRC_ALU    = 2'd2;
  localparam logic [1:0] SRC_RETIRE = 2'd3;

  localparam int unsigned DISPLAY_MAX = 9999;
  localparam int unsigned CLK_HZ      = 100_000_000;

  typedef struct packed {
    logic [15:0] value;
    logic        overflow;
  } clamp_t;

  // Unsigned 16-bit saturation to the largest value four decimal digits can show.
  function automatic clamp_t clamp_value(input logic [15:0] raw, input logic [15:0] max_val);
    clamp_t r;
    if (raw > max_val) begin
      r.value    = max_val;
      r.overflow = 1'b1;
    end else begin
      r.value    = raw;
      r.overflow = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button synchronizer and debouncer with a single-cycle press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          settle;

  // The counter measures how long the synced level has disagreed with the accepted one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d   = cnt_q;
    level_d = level_q;
    settle  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (settle) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = settle & sync2_q;

endmodule

// File: rtl/display_source_sampler.sv
// Selects a debug source by push-button, clamps it to four digits and re-samples it slowly.
module display_source_sampler
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int unsigned SAMPLE_CYCLES   = CLK_HZ / 4,
  parameter int unsigned MAX_VALUE       = DISPLAY_MAX
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        btn_next,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [15:0] dbg_pc,
  input  logic [15:0] dbg_alu,
  input  logic        instr_retire,
  input  logic        clr_cnt,
  output logic [15:0] data_o,
  output logic [1:0]  sel_o,
  output logic        overflow_o
);

  localparam int unsigned TW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_CYCLES - 1);
  localparam logic [15:0]   MAX_V      = 16'(MAX_VALUE);

  logic          btn_level, btn_rise, advance;
  logic [1:0]    sel_q, sel_d;
  logic          force_q;
  logic [15:0]   mmio_q, mmio_d;
  logic [15:0]   retire_q, retire_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   data_q, data_d;
  logic          ovf_q, ovf_d;
  logic          sample;
  logic [15:0]   src_val;
  clamp_t        clamped;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .btn_raw      (btn_next),
    .btn_level    (btn_level),
    .btn_rise     (btn_rise)
  );

  // Only a low-to-high transition of the accepted level advances the selection.
  assign advance = btn_rise & ~btn_level;

  always_comb begin
    sel_d    = advance ? sel_q + 2'd1 : sel_q;
    mmio_d   = wr_en ? wr_data : mmio_q;
    retire_d = retire_q;
    if (clr_cnt)                             retire_d = '0;
    else if (instr_retire && retire_q != '1) retire_d = retire_q + 16'd1;

    sample  = (timer_q == TIMER_LAST) || force_q;
    timer_d = sample ? '0 : timer_q + 1'b1;

    case (sel_q)
      SRC_MMIO: src_val = mmio_q;
      SRC_PC:   src_val = dbg_pc;
      SRC_ALU:  src_val = dbg_alu;
      default:  src_val = retire_q;
    endcase
    clamped = clamp_value(src_val, MAX_V);

    data_d = sample ? clamped.value    : data_q;
    ovf_d  = sample ? clamped.overflow : ovf_q;
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sel_q    <= '0;
      force_q  <= 1'b0;
      mmio_q   <= '0;
      retire_q <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      force_q  <= advance;
      mmio_q   <= mmio_d;
      retire_q <= retire_d;
      timer_q  <= timer_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_o     = data_q;
  assign sel_o      = sel_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_display_source_sampler.sv
// Directed bench for display_source_sampler with short debounce and sample periods.
module tb_display_source_sampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] dbg_pc;
  logic [15:0] dbg_alu;
  logic        instr_retire;
  logic        clr_cnt;
  logic [15:0] data_o;
  logic [1:0]  sel_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  display_source_sampler #(
    .DEBOUNCE_CYCLES (4),
    .SAMPLE_CYCLES   (8),
    .MAX_VALUE       (9999)
  ) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .btn_next     (btn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .dbg_pc       (dbg_pc),
    .dbg_alu      (dbg_alu),
    .instr_retire (instr_retire),
    .clr_cnt      (clr_cnt),
    .data_o       (data_o),
    .sel_o        (sel_o),
    .overflow_o   (overflow_o)
  );

  typedef struct {
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    step(hold);
    btn = 1'b0;
    step(12);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] prev_data;
    logic        prev_ovf;
    int          waited;

    rst = 1'b1; btn = 1'b0; wr_en = 1'b0; wr_data = '0;
    dbg_pc = '0; dbg_alu = '0; instr_retire = 1'b0; clr_cnt = 1'b0;

    vecs[0] = '{16'd1234,  16'd1234, 1'b0};
    vecs[1] = '{16'd42,    16'd42,   1'b0};
    vecs[2] = '{16'd10000, 16'd9999, 1'b1};
    vecs[3] = '{16'd9999,  16'd9999, 1'b0};
    vecs[4] = '{16'd0,     16'd0,    1'b0};
    vecs[5] = '{16'hFFFF,  16'd9999, 1'b1};
    vecs[6] = '{16'd11,    16'd11,   1'b0};

    #1;
    check("reset data", data_o, 0);
    check("reset sel", sel_o, 0);
    check("reset ovf", overflow_o, 0);
    step(2);
    rst = 1'b0;

    // Timer is 0 at release, so data updates on the 8th, 16th, ... edge afterwards.
    prev_data = '0;
    prev_ovf  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      wr_en = 1'b1; wr_data = vecs[i].wdata;
      step(1);
      wr_en = 1'b0;
      step(5);
      check($sformatf("hold data v%0d", i), data_o, prev_data);
      check($sformatf("hold ovf v%0d", i), overflow_o, prev_ovf);
      step(1);
      check($sformatf("sample data v%0d", i), data_o, vecs[i].exp_data);
      check($sformatf("sample ovf v%0d", i), overflow_o, vecs[i].exp_ovf);
      prev_data = vecs[i].exp_data;
      prev_ovf  = vecs[i].exp_ovf;
    end

    // Write lands in the tick cycle: the sample takes the pre-write value.
    step(7);
    wr_en = 1'b1; wr_data = 16'd77;
    step(1);
    wr_en = 1'b0;
    check("collision old value", data_o, 11);
    step(8);
    check("collision new value", data_o, 77);

    step(3);
    rst = 1'b1;
    #1;
    check("midcount reset data", data_o, 0);
    check("midcount reset sel", sel_o, 0);
    check("midcount reset ovf", overflow_o, 0);
    step(1);
    rst = 1'b0;
    step(9);
    check("mmio cleared by reset", data_o, 0);

    dbg_pc  = 16'h0100;
    dbg_alu = 16'd4660;
    btn = 1'b1;
    step(2);
    btn = 1'b0;
    step(15);
    check("glitch ignored", sel_o, 0);

    btn = 1'b1;
    waited = 0;
    while (sel_o == 2'd0 && waited < 20) begin
      step(1);
      waited++;
    end
    check("first press sel", sel_o, 1);
    waited = 0;
    while (data_o != 16'd256 && waited < 2) begin
      step(1);
      waited++;
    end
    check("forced pc sample", data_o, 256);
    step(10);
    check("held press single step", sel_o, 1);
    btn = 1'b0;
    step(12);
    check("release no step", sel_o, 1);

    press(12);
    check("second press sel", sel_o, 2);
    check("alu sample", data_o, 4660);
    check("alu ovf", overflow_o, 0);
    press(12);
    check("third press sel", sel_o, 3);
    check("retire zero", data_o, 0);

    repeat (5) begin
      instr_retire = 1'b1;
      step(1);
      instr_retire = 1'b0;
      step(1);
    end
    step(9);
    check("retire count 5", data_o, 5);
    clr_cnt = 1'b1; instr_retire = 1'b1;
    step(1);
    clr_cnt = 1'b0; instr_retire = 1'b0;
    step(9);
    check("clear beats retire", data_o, 0);

    instr_retire = 1'b1;
    step(70000);
    instr_retire = 1'b0;
    step(9);
    check("retire saturated data", data_o, 9999);
    check("retire saturated ovf", overflow_o, 1);
    instr_retire = 1'b1;
    step(1);
    instr_retire = 1'b0;
    step(9);
    check("retire stays saturated", data_o, 9999);

    press(12);
    check("fourth press wraps sel", sel_o, 0);
    check("wrap mmio data", data_o, 0);
    check("wrap ovf cleared", overflow_o, 0);

    press(12);
    check("pre-reset sel", sel_o, 1);
    rst = 1'b1;
    #1;
    check("final reset sel", sel_o, 0);
    check("final reset data", data_o, 0);
    step(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
